// File: rtl/spi_byte_master_if.sv
// Handshake and SPI pin bundle for spi_byte_master.
// The master modport is the DUT view; slave is the caller/flash-side view.
interface spi_byte_master_if;
  logic       start_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       done_o;
  logic       busy_o;
  logic       spi_sck_o;
  logic       spi_mosi_o;
  logic       spi_miso_i;

  modport master (
    input  start_i, data_i, spi_miso_i,
    output data_o, done_o, busy_o, spi_sck_o, spi_mosi_o
  );

  modport slave (
    output start_i, data_i, spi_miso_i,
    input  data_o, done_o, busy_o, spi_sck_o, spi_mosi_o
  );
endinterface

// File: rtl/spi_byte_master.sv
// Byte-wide SPI mode-0 master, MSB first; one byte per start request.
// SCK half-period is CLK_DIV clk cycles; done pulses one cycle with the received byte.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  spi_byte_master_if.master  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t           r_state;
  logic [6:0]       r_tx_shift;   // bits still to send after the one on MOSI
  logic [7:0]       r_rx_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sck;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_data;

  assign bus.spi_sck_o  = r_sck;
  assign bus.spi_mosi_o = r_mosi;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.data_o     = r_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sck <= 1'b0;
          if (bus.start_i) begin
            r_tx_shift <= bus.data_i[6:0];
            r_mosi     <= bus.data_i[7];
            r_div_cnt  <= DIV_RELOAD;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_LOW;
          end
        end

        S_LOW: begin
          if (r_div_cnt == '0) begin
            r_sck      <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], bus.spi_miso_i};
            r_div_cnt  <= DIV_RELOAD;
            r_state    <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end

        S_HIGH: begin
          if (r_div_cnt == '0) begin
            r_sck <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              // rx_shift already holds all 8 bits; the last one came in on this byte's final rise
              r_done    <= 1'b1;
              r_data    <= r_rx_shift;
              r_busy    <= 1'b0;
              r_mosi    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              r_mosi     <= r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              r_div_cnt  <= DIV_RELOAD;
              r_state    <= S_LOW;
            end
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end

        default: begin
          r_sck   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: CLK_DIV=2 and CLK_DIV=1 instances share one slave model.
module tb_spi_byte_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sel    = 1'b0;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic       start  = 1'b0;
  logic [7:0] data   = 8'h00;
  logic [7:0] s_byte = 8'h00;
  logic       s_load = 1'b0;
  logic [7:0] s_reg  = 8'h00;

  int         rises    = 0;
  logic [7:0] mosi_cap = 8'h00;
  int         total    = 0;
  int         bad      = 0;

  int done_edge, busy_cnt, high_cnt, run, cur_div, dcnt;
  logic phase_bad, prev_sck, hold_ok;

  spi_byte_master_if ifA ();
  spi_byte_master_if ifB ();

  spi_byte_master #(.CLK_DIV(2)) dutA (.clk_i(clk), .reset_i(rst), .bus(ifA.master));
  spi_byte_master #(.CLK_DIV(1)) dutB (.clk_i(clk), .reset_i(rst), .bus(ifB.master));

  assign ifA.start_i    = start & ~sel;
  assign ifB.start_i    = start & sel;
  assign ifA.data_i     = data;
  assign ifB.data_i     = data;
  assign ifA.spi_miso_i = s_reg[7];
  assign ifB.spi_miso_i = s_reg[7];

  logic       w_sck, w_mosi, w_busy, w_done;
  logic [7:0] w_data;
  assign w_sck  = sel ? ifB.spi_sck_o  : ifA.spi_sck_o;
  assign w_mosi = sel ? ifB.spi_mosi_o : ifA.spi_mosi_o;
  assign w_busy = sel ? ifB.busy_o     : ifA.busy_o;
  assign w_done = sel ? ifB.done_o     : ifA.done_o;
  assign w_data = sel ? ifB.data_o     : ifA.data_o;

  // Mode-0 slave: bit 7 presented before the first rise, shift on every SCK fall
  always @(negedge w_sck or posedge s_load) begin
    if (s_load) s_reg = s_byte;
    else        s_reg = {s_reg[6:0], 1'b0};
  end

  always @(posedge w_sck or posedge s_load) begin
    if (s_load) begin
      rises    = 0;
      mosi_cap = 8'h00;
    end else begin
      rises++;
      mosi_cap = {mosi_cap[6:0], w_mosi};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_now(input logic [7:0] tx, input logic [7:0] sb);
    data   = tx;
    start  = 1'b1;
    s_byte = sb;
    s_load = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    s_load = 1'b0;
    chk("edge0 busy", w_busy, 1);
    chk("edge0 done", w_done, 0);
    chk("edge0 mosi", w_mosi, tx[7]);
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sb);
    @(negedge clk);
    start_now(tx, sb);
  endtask

  task automatic wait_done(input int inj);
    done_edge = -1;
    busy_cnt  = 1;
    high_cnt  = 0;
    phase_bad = 1'b0;
    prev_sck  = w_sck;
    run       = 1;
    cur_div   = sel ? 1 : 2;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (e == inj) begin
        start = 1'b1;
        data  = 8'hFF;
      end else if (e == inj + 1) begin
        start = 1'b0;
      end
      if (w_sck !== prev_sck) begin
        if (run != cur_div) phase_bad = 1'b1;
        run      = 1;
        prev_sck = w_sck;
      end else begin
        run++;
      end
      if (w_done === 1'b1) begin
        done_edge = e;
        break;
      end
      if (w_busy === 1'b1) busy_cnt++;
      if (w_sck === 1'b1)  high_cnt++;
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset sck",  ifA.spi_sck_o, 0);
    chk("reset mosi", ifA.spi_mosi_o, 0);
    chk("reset busy", ifA.busy_o, 0);
    chk("reset done", ifA.done_o, 0);
    chk("reset data", ifA.data_o, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: 0x03 out, slave returns 0xA5
    start_xfer(8'h03, 8'hA5);
    wait_done(-10);
    chk("t1 done edge",   done_edge, 32);
    chk("t1 busy cycles", busy_cnt, 32);
    chk("t1 sck high",    high_cnt, 16);
    chk("t1 phase len",   phase_bad, 0);
    chk("t1 rises",       rises, 8);
    chk("t1 mosi",        mosi_cap, 8'h03);
    chk("t1 data",        w_data, 8'hA5);
    chk("t1 busy@done",   w_busy, 0);
    chk("t1 sck@done",    w_sck, 0);

    // 2: back-to-back start in the done cycle
    start_now(8'h00, 8'h3C);
    wait_done(-10);
    chk("t2 done edge", done_edge, 32);
    chk("t2 phase len", phase_bad, 0);
    chk("t2 rises",     rises, 8);
    chk("t2 mosi",      mosi_cap, 8'h00);
    chk("t2 data",      w_data, 8'h3C);
    @(posedge clk); #1;
    chk("t2 done width", w_done, 0);

    // 3: start while busy is ignored
    start_xfer(8'h03, 8'hA5);
    wait_done(10);
    chk("t3 done edge", done_edge, 32);
    chk("t3 mosi",      mosi_cap, 8'h03);
    chk("t3 data",      w_data, 8'hA5);
    dcnt    = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (w_done === 1'b1) dcnt++;
      if (w_busy !== 1'b0) hold_ok = 1'b0;
    end
    chk("t3 extra done", dcnt, 0);
    chk("t3 idle busy",  hold_ok, 1);

    // 4: async reset between 3rd and 4th SCK rise
    start_xfer(8'hFF, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (rises == 3) break;
      @(posedge clk); #1;
    end
    chk("t4 reached rise3", rises, 3);
    @(posedge clk); #2;
    chk("t4 pre sck",  w_sck, 1);
    chk("t4 pre mosi", w_mosi, 1);
    rst = 1'b1;
    #1;
    chk("t4 rst sck",  w_sck, 0);
    chk("t4 rst mosi", w_mosi, 0);
    chk("t4 rst busy", w_busy, 0);
    chk("t4 rst data", w_data, 8'h00);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (w_done === 1'b1) dcnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (w_done === 1'b1) dcnt++;
    end
    chk("t4 no done", dcnt, 0);
    start_xfer(8'h5A, 8'hC3);
    wait_done(-10);
    chk("t4 done edge", done_edge, 32);
    chk("t4 mosi",      mosi_cap, 8'h5A);
    chk("t4 data",      w_data, 8'hC3);

    // 5: CLK_DIV=1 instance
    @(negedge clk);
    sel = 1'b1;
    start_xfer(8'h9B, 8'h6E);
    wait_done(-10);
    chk("t5 done edge",   done_edge, 16);
    chk("t5 busy cycles", busy_cnt, 16);
    chk("t5 sck high",    high_cnt, 8);
    chk("t5 phase len",   phase_bad, 0);
    chk("t5 rises",       rises, 8);
    chk("t5 mosi",        mosi_cap, 8'h9B);
    chk("t5 data",        w_data, 8'h6E);

    // 6: MISO all ones, hold through idle, then all zeros
    @(negedge clk);
    sel = 1'b0;
    start_xfer(8'h00, 8'hFF);
    wait_done(-10);
    chk("t6 data ff", w_data, 8'hFF);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (w_data !== 8'hFF) hold_ok = 1'b0;
    end
    chk("t6 hold", hold_ok, 1);
    start_xfer(8'h00, 8'h00);
    wait_done(-10);
    chk("t6 done edge", done_edge, 32);
    chk("t6 data 00",   w_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. It sits directly downstream of the boot FSM. It accepts single-byte start requests, shifts the byte out on MOSI while shifting a byte in from MISO, then returns the received byte with a one-cycle done pulse. Chip select is not generated here; the boot FSM drives flash CSB itself.

Parameters:
CLK_DIV, 2, number of clk_i cycles per SCK half-period; legal range >= 1; SCK frequency = f_clk / (2*CLK_DIV).

Ports:
clk_i  input  1  system clock; all logic is on its rising edge
reset_i  input  1  asynchronous active-high reset
start_i  input  1  request one byte transfer; sampled only when not busy
data_i  input  8  byte to transmit; captured on the edge that accepts start_i
data_o  output  8  last received byte; valid from the done_o cycle, held until the next done_o
done_o  output  1  one-cycle pulse: transfer complete
busy_o  output  1  high while a transfer is in progress
spi_sck_o  output  1  SPI clock, registered, idles low
spi_mosi_o  output  1  serial data out, registered
spi_miso_i  input  1  serial data in

Behaviour:
- Clock and reset: one clock (clk_i). reset_i is asynchronous and active-high.
- On reset assertion, immediately:
  - FSM goes to IDLE.
  - spi_sck_o=0, spi_mosi_o=0, busy_o=0, done_o=0, data_o=8'h00.
  - Shift registers, bit counter and divider counter are cleared.
- Reset mid-transfer aborts the byte. No done_o is produced and no partial data reaches data_o.
- States:
  - IDLE: sck=0, busy=0, mosi holds 0. If start_i=1: load tx_shift=data_i, drive mosi=data_i[7], set div_cnt=CLK_DIV-1, set bit_cnt=0, go to LOW.
  - LOW: sck=0. Decrement div_cnt each cycle. When div_cnt==0: set sck=1, sample spi_miso_i into rx_shift LSB (rx_shift shifts left), reload div_cnt, go to HIGH.
  - HIGH: sck=1. Decrement div_cnt each cycle. When div_cnt==0: set sck=0, increment bit_cnt.
    - If bit_cnt was 7: set done_o=1 and data_o=rx_shift (already holding all 8 bits), go to IDLE.
    - Otherwise: shift tx_shift left, drive mosi=next bit, reload div_cnt, go to LOW.
- busy_o is registered and equals (state != IDLE).
- Latency: with edge 0 being the edge that accepts start_i:
  - busy_o is high after edges 0 .. 16*CLK_DIV-1.
  - Edge 16*CLK_DIV clears busy_o and sets done_o for exactly one cycle.
  - Exactly 8 SCK rising edges per byte; each SCK phase lasts exactly CLK_DIV clk cycles.
- MOSI changes only on edges that drive SCK low, plus the start-accept edge. It is stable across every SCK rising edge.
- MISO is sampled on the clk edge that raises SCK (mode 0). The slave shifts on SCK falling edges.
- start_i while busy is ignored entirely; data_i is not recaptured.
- start_i in the done_o cycle (FSM already in IDLE) is accepted. The next transfer starts with no idle SCK gap beyond that cycle. done_o deasserts and busy_o asserts on the following edge.
- data_o changes only on done edges or reset.
- div_cnt width is max(1, $clog2(CLK_DIV)). bit_cnt is 3 bits and never wraps mid-byte.
- Back-pressure and multi-byte framing are the caller's responsibility. There is no internal buffering.

Test Plan:
1. CLK_DIV=2, data_i=8'h03, slave model returns 8'hA5 → MOSI bits sampled at SCK rises are 0,0,0,0,0,0,1,1. Exactly 8 SCK pulses, 2 clk high and 2 clk low each. busy_o high for 32 cycles. done_o pulses at edge 32 with data_o=8'hA5 and busy_o=0.
2. Back-to-back: assert start_i with data_i=8'h00 in the done_o cycle of test 1 → busy_o=1 on the next edge, second done_o 32 edges later with data_o equal to the model's second byte (8'h3C). No glitch or extra pulse on SCK.
3. start_i=1 with data_i=8'hFF at cycle 10 of a busy transfer of 8'h03 → ignored. MOSI sequence unchanged and exactly one done_o.
4. Async reset asserted between the 3rd and 4th SCK rise → sck/mosi/busy/data_o go to 0 without waiting for a clock edge. No done_o. A new transfer of 8'h5A with the model returning 8'hC3 then completes with data_o=8'hC3.
5. CLK_DIV=1, data_i=8'h9B → SCK period is 2 clk and done_o is at edge 16. MOSI pattern is 1,0,0,1,1,0,1,1.
6. MISO tied 1 → data_o=8'hFF. Then MISO tied 0 → data_o=8'h00. data_o holds its value through 20 idle cycles between transfers.
